// File: rtl/xilinx_boot_sequencer.sv
// -----------------------------------------------------------------------------
// xilinx_boot_sequencer
//
// Purpose:
//   Power-up / reset sequencer for the FPGA top. It works through these steps
//   in order:
//     1. Wait for the clock wizard lock to be stable for a debounce window.
//     2. Hold the DRAM MIG in reset.
//     3. Wait for DRAM calibration to complete.
//     4. Hold the SoC in reset for a fixed window.
//     5. Release the SoC and latch the boot mode at the moment of release.
//   Losing lock, an external reset request or a DRAM calibration drop in RUN
//   restarts the appropriate part of the sequence. A calibration timeout
//   parks the FSM in FAULT and raises a sticky flag.
//
// Ports:
//   clk_i              in   1  SoC clock
//   rst_i              in   1  synchronous, active-high reset
//   clk_locked_i       in   1  clock wizard locked, synchronous to clk_i
//   ext_rst_i          in   1  board/VIO reset request, active-high
//   boot_mode_i        in   2  raw boot mode (switches / VIO mux)
//   dram_calib_done_i  in   1  MIG init_calib_complete
//   dram_rst_o         out  1  MIG reset, active-high
//   soc_rst_no         out  1  SoC/USB reset, active-low
//   boot_mode_o        out  2  boot mode latched at SoC release
//   ready_o            out  1  high only in RUN
//   calib_timeout_o    out  1  sticky calibration timeout flag
//   state_o            out  3  current state encoding, for VIO/ILA
// -----------------------------------------------------------------------------
module xilinx_boot_sequencer #(
  parameter int LockDebounceCycles = 1024,
  parameter int DramRstCycles      = 64,
  parameter int CalibTimeoutCycles = 2**24,
  parameter int SocRstCycles       = 32,
  parameter bit UseDram            = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clk_locked_i,
  input  logic       ext_rst_i,
  input  logic [1:0] boot_mode_i,
  input  logic       dram_calib_done_i,
  output logic       dram_rst_o,
  output logic       soc_rst_no,
  output logic [1:0] boot_mode_o,
  output logic       ready_o,
  output logic       calib_timeout_o,
  output logic [2:0] state_o
);

  // One shared counter, sized for the longest of the four cycle windows.
  localparam int MaxAB     = (LockDebounceCycles > DramRstCycles) ? LockDebounceCycles : DramRstCycles;
  localparam int MaxCD     = (CalibTimeoutCycles > SocRstCycles) ? CalibTimeoutCycles : SocRstCycles;
  localparam int MaxCycles = (MaxAB > MaxCD) ? MaxAB : MaxCD;
  localparam int CntW      = $clog2(MaxCycles) + 1;

  // Each window ends in the cycle where the counter shows (length - 1),
  // because the counter starts at 0 on the first cycle spent in a state.
  localparam logic [CntW-1:0] LockLast  = CntW'(LockDebounceCycles - 1);
  localparam logic [CntW-1:0] DramLast  = CntW'(DramRstCycles - 1);
  localparam logic [CntW-1:0] CalibLast = CntW'(CalibTimeoutCycles - 1);
  localparam logic [CntW-1:0] SocLast   = CntW'(SocRstCycles - 1);

  typedef enum logic [2:0] {
    StWaitLock  = 3'd0,
    StDramRst   = 3'd1,
    StWaitCalib = 3'd2,
    StSocRst    = 3'd3,
    StRun       = 3'd4,
    StFault     = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dram_rst_q, dram_rst_d;
  logic            soc_rst_n_q, soc_rst_n_d;
  logic            ready_q, ready_d;
  logic            calib_timeout_q, calib_timeout_d;
  logic [1:0]      boot_mode_q, boot_mode_d;

  // Next-state logic. An external reset request beats lock loss, and lock
  // loss beats any normal transition. While ext_rst_i is held the FSM stays
  // in WAIT_LOCK with a cleared counter, so debouncing only starts once the
  // request is released. In WAIT_LOCK a lock drop does not change the state;
  // it only restarts the debounce window through the counter below.
  always_comb begin
    state_d = state_q;
    if (ext_rst_i) begin
      state_d = StWaitLock;
    end else if (!clk_locked_i && (state_q != StWaitLock)) begin
      state_d = StWaitLock;
    end else begin
      case (state_q)
        StWaitLock: begin
          if (clk_locked_i && (cnt_q == LockLast)) begin
            state_d = UseDram ? StDramRst : StSocRst;
          end
        end
        StDramRst: begin
          if (cnt_q == DramLast) begin
            state_d = StWaitCalib;
          end
        end
        StWaitCalib: begin
          // Calibration completing on the last allowed cycle still counts
          // as success, so done is tested before the timeout.
          if (dram_calib_done_i) begin
            state_d = StSocRst;
          end else if (cnt_q == CalibLast) begin
            state_d = StFault;
          end
        end
        StSocRst: begin
          if (cnt_q == SocLast) begin
            state_d = StRun;
          end
        end
        StRun: begin
          // A calibration drop forces a full DRAM re-init with the SoC held.
          if (UseDram && !dram_calib_done_i) begin
            state_d = StDramRst;
          end
        end
        StFault: begin
          state_d = StFault;
        end
        default: begin
          state_d = StWaitLock;
        end
      endcase
    end
  end

  // Shared cycle counter. It clears on any state change and on an external
  // reset request. In WAIT_LOCK it also clears on every unlocked cycle, so it
  // counts consecutive locked cycles only. RUN and FAULT have no window to
  // time, so the counter rests at zero there.
  always_comb begin
    cnt_d = '0;
    if (ext_rst_i || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q == StWaitLock) && !clk_locked_i) begin
      cnt_d = '0;
    end else if (state_q inside {StWaitLock, StDramRst, StWaitCalib, StSocRst}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Output decode from the next state, so every registered output changes on
  // the same edge as the state itself. Without a DRAM the MIG reset is held
  // asserted permanently. The boot mode is captured only on the release edge,
  // and the timeout flag is sticky until rst_i.
  always_comb begin
    dram_rst_d      = !UseDram || (state_d inside {StWaitLock, StDramRst, StFault});
    soc_rst_n_d     = (state_d == StRun);
    ready_d         = (state_d == StRun);
    calib_timeout_d = calib_timeout_q || ((state_q == StWaitCalib) && (state_d == StFault));
    boot_mode_d     = boot_mode_q;
    if ((state_q == StSocRst) && (state_d == StRun)) begin
      boot_mode_d = boot_mode_i;
    end
  end

  // State, counter and output registers. The synchronous reset puts the
  // FSM back in WAIT_LOCK and puts every output in its safe reset value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= StWaitLock;
      cnt_q           <= '0;
      dram_rst_q      <= 1'b1;
      soc_rst_n_q     <= 1'b0;
      ready_q         <= 1'b0;
      calib_timeout_q <= 1'b0;
      boot_mode_q     <= 2'b00;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      dram_rst_q      <= dram_rst_d;
      soc_rst_n_q     <= soc_rst_n_d;
      ready_q         <= ready_d;
      calib_timeout_q <= calib_timeout_d;
      boot_mode_q     <= boot_mode_d;
    end
  end

  assign dram_rst_o      = dram_rst_q;
  assign soc_rst_no      = soc_rst_n_q;
  assign ready_o         = ready_q;
  assign calib_timeout_o = calib_timeout_q;
  assign boot_mode_o     = boot_mode_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_xilinx_boot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_xilinx_boot_sequencer
//
// Purpose:
//   Self-checking bench for xilinx_boot_sequencer. Two instances share one
//   set of inputs: dutA with DRAM enabled and dutB without DRAM. A timestamp
//   based reference model predicts both every cycle. A vector table covers
//   the normal boot, hand sequences cover the multi-cycle corner cases, and
//   a randomized phase stresses resets, lock loss and calibration loss.
// -----------------------------------------------------------------------------
module tb_xilinx_boot_sequencer;

  localparam int LockN  = 4;
  localparam int DramN  = 3;
  localparam int CalibN = 16;
  localparam int SocN   = 2;

  // Phase numbers as they appear on state_o.
  localparam int PhWaitLock  = 0;
  localparam int PhDramRst   = 1;
  localparam int PhWaitCalib = 2;
  localparam int PhSocRst    = 3;
  localparam int PhRun       = 4;
  localparam int PhFault     = 5;

  logic       clk = 1'b0;
  logic       rst, locked, extRst, calibDone;
  logic [1:0] bootMode;

  logic       aDram, aSocN, aReady, aTo;
  logic [1:0] aBmo;
  logic [2:0] aState;
  logic       bDram, bSocN, bReady, bTo;
  logic [1:0] bBmo;
  logic [2:0] bState;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int now    = 0;

  // Model state, index 0 = dutA (DRAM), index 1 = dutB (no DRAM). Phases are
  // tracked through the cycle number at which they were entered.
  int         mPhase[2];
  int         mEntry[2];
  int         mLockStart[2];
  logic       mTo[2];
  logic [1:0] mBoot[2];

  always #5 clk = ~clk;

  xilinx_boot_sequencer #(
    .LockDebounceCycles(LockN),
    .DramRstCycles(DramN),
    .CalibTimeoutCycles(CalibN),
    .SocRstCycles(SocN),
    .UseDram(1'b1)
  ) dutA (
    .clk_i(clk),
    .rst_i(rst),
    .clk_locked_i(locked),
    .ext_rst_i(extRst),
    .boot_mode_i(bootMode),
    .dram_calib_done_i(calibDone),
    .dram_rst_o(aDram),
    .soc_rst_no(aSocN),
    .boot_mode_o(aBmo),
    .ready_o(aReady),
    .calib_timeout_o(aTo),
    .state_o(aState)
  );

  xilinx_boot_sequencer #(
    .LockDebounceCycles(LockN),
    .DramRstCycles(DramN),
    .CalibTimeoutCycles(CalibN),
    .SocRstCycles(SocN),
    .UseDram(1'b0)
  ) dutB (
    .clk_i(clk),
    .rst_i(rst),
    .clk_locked_i(locked),
    .ext_rst_i(extRst),
    .boot_mode_i(bootMode),
    .dram_calib_done_i(calibDone),
    .dram_rst_o(bDram),
    .soc_rst_no(bSocN),
    .boot_mode_o(bBmo),
    .ready_o(bReady),
    .calib_timeout_o(bTo),
    .state_o(bState)
  );

  typedef struct {
    logic       locked;
    logic       calib;
    logic [1:0] bm;
    logic [2:0] expState;
    logic       expDram;
    logic       expSocN;
    logic [1:0] expBmo;
    logic [2:0] expBState;
  } vec_t;

  vec_t vecs[11];

  // Single comparison with failure reporting.
  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, actual, expected);
    end
  endtask

  // Moves a model instance into a new phase starting next cycle.
  task automatic goTo(input int d, input int p);
    mPhase[d]     = p;
    mEntry[d]     = now + 1;
    mLockStart[d] = now + 1;
  endtask

  // Advances the reference model across one clock edge.
  task automatic modelStep(input logic r, input logic l, input logic e, input logic c, input logic [1:0] b);
    int  spent;
    bit  useDram;
    now++;
    for (int d = 0; d < 2; d++) begin
      useDram = (d == 0);
      spent   = now - mEntry[d] + 1;
      if (r) begin
        goTo(d, PhWaitLock);
        mTo[d]   = 1'b0;
        mBoot[d] = 2'b00;
      end else if (e) begin
        goTo(d, PhWaitLock);
      end else if (!l && mPhase[d] != PhWaitLock) begin
        goTo(d, PhWaitLock);
      end else begin
        case (mPhase[d])
          PhWaitLock: begin
            if (!l) mLockStart[d] = now + 1;
            else if (now - mLockStart[d] + 1 == LockN) goTo(d, useDram ? PhDramRst : PhSocRst);
          end
          PhDramRst: if (spent == DramN) goTo(d, PhWaitCalib);
          PhWaitCalib: begin
            if (c) goTo(d, PhSocRst);
            else if (spent == CalibN) begin
              goTo(d, PhFault);
              mTo[d] = 1'b1;
            end
          end
          PhSocRst: begin
            if (spent == SocN) begin
              goTo(d, PhRun);
              mBoot[d] = b;
            end
          end
          PhRun: if (useDram && !c) goTo(d, PhDramRst);
          default: ;
        endcase
      end
    end
  endtask

  // Compares both instances against the model's view of the current cycle.
  task automatic compareModel();
    logic expDramA;
    expDramA = (mPhase[0] == PhWaitLock) || (mPhase[0] == PhDramRst) || (mPhase[0] == PhFault);
    checkOutput("A.state", 8'(aState), 8'(mPhase[0]));
    checkOutput("A.dram_rst", 8'(aDram), 8'(expDramA));
    checkOutput("A.soc_rst_n", 8'(aSocN), 8'(mPhase[0] == PhRun));
    checkOutput("A.ready", 8'(aReady), 8'(mPhase[0] == PhRun));
    checkOutput("A.timeout", 8'(aTo), 8'(mTo[0]));
    checkOutput("A.boot_mode", 8'(aBmo), 8'(mBoot[0]));
    checkOutput("B.state", 8'(bState), 8'(mPhase[1]));
    checkOutput("B.dram_rst", 8'(bDram), 8'd1);
    checkOutput("B.soc_rst_n", 8'(bSocN), 8'(mPhase[1] == PhRun));
    checkOutput("B.ready", 8'(bReady), 8'(mPhase[1] == PhRun));
    checkOutput("B.timeout", 8'(bTo), 8'(mTo[1]));
    checkOutput("B.boot_mode", 8'(bBmo), 8'(mBoot[1]));
  endtask

  // Drives one cycle of inputs, crosses the edge and checks the result.
  // On return cyc names the cycle whose outputs are now visible.
  task automatic applyStimulus(input logic r, input logic l, input logic e, input logic c, input logic [1:0] b);
    rst       = r;
    locked    = l;
    extRst    = e;
    calibDone = c;
    bootMode  = b;
    @(posedge clk);
    modelStep(r, l, e, c, b);
    #1;
    cyc++;
    compareModel();
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    cyc = 1;
  endtask

  initial begin
    logic [1:0] bm;
    for (int d = 0; d < 2; d++) begin
      mPhase[d]     = PhWaitLock;
      mEntry[d]     = 1;
      mLockStart[d] = 1;
      mTo[d]        = 1'b0;
      mBoot[d]      = 2'b00;
    end

    // Normal boot: row n holds the inputs of cycle n and the outputs
    // expected in cycle n+1.
    vecs[0]  = '{1'b1, 1'b1, 2'b10, 3'd0, 1'b1, 1'b0, 2'b00, 3'd0};
    vecs[1]  = '{1'b1, 1'b1, 2'b10, 3'd0, 1'b1, 1'b0, 2'b00, 3'd0};
    vecs[2]  = '{1'b1, 1'b1, 2'b10, 3'd0, 1'b1, 1'b0, 2'b00, 3'd0};
    vecs[3]  = '{1'b1, 1'b1, 2'b10, 3'd1, 1'b1, 1'b0, 2'b00, 3'd3};
    vecs[4]  = '{1'b1, 1'b1, 2'b10, 3'd1, 1'b1, 1'b0, 2'b00, 3'd3};
    vecs[5]  = '{1'b1, 1'b1, 2'b10, 3'd1, 1'b1, 1'b0, 2'b00, 3'd4};
    vecs[6]  = '{1'b1, 1'b1, 2'b10, 3'd2, 1'b0, 1'b0, 2'b00, 3'd4};
    vecs[7]  = '{1'b1, 1'b1, 2'b10, 3'd3, 1'b0, 1'b0, 2'b00, 3'd4};
    vecs[8]  = '{1'b1, 1'b1, 2'b10, 3'd3, 1'b0, 1'b0, 2'b00, 3'd4};
    vecs[9]  = '{1'b1, 1'b1, 2'b10, 3'd4, 1'b0, 1'b1, 2'b10, 3'd4};
    vecs[10] = '{1'b1, 1'b1, 2'b10, 3'd4, 1'b0, 1'b1, 2'b10, 3'd4};

    $display("[TB] reset and normal boot");
    doReset();
    checkOutput("reset.state", 8'(aState), 8'd0);
    checkOutput("reset.dram_rst", 8'(aDram), 8'd1);
    checkOutput("reset.soc_rst_n", 8'(aSocN), 8'd0);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b0, vecs[i].locked, 1'b0, vecs[i].calib, vecs[i].bm);
      checkOutput("boot.state", 8'(aState), 8'(vecs[i].expState));
      checkOutput("boot.dram_rst", 8'(aDram), 8'(vecs[i].expDram));
      checkOutput("boot.soc_rst_n", 8'(aSocN), 8'(vecs[i].expSocN));
      checkOutput("boot.ready", 8'(aReady), 8'(vecs[i].expSocN));
      checkOutput("boot.boot_mode", 8'(aBmo), 8'(vecs[i].expBmo));
      checkOutput("nodram.state", 8'(bState), 8'(vecs[i].expBState));
      checkOutput("nodram.dram_rst", 8'(bDram), 8'd1);
    end

    $display("[TB] lock glitch");
    doReset();
    for (int n = 1; n <= 14; n++) begin
      applyStimulus(1'b0, (n != 3), 1'b0, 1'b1, 2'b01);
      if (cyc == 13) checkOutput("glitch.soc_rst_n13", 8'(aSocN), 8'd0);
      if (cyc == 14) checkOutput("glitch.soc_rst_n14", 8'(aSocN), 8'd1);
    end

    $display("[TB] calibration timeout and recovery");
    doReset();
    for (int n = 1; n <= 26; n++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
      if (cyc == 23) checkOutput("timeout.state23", 8'(aState), 8'd2);
      if (cyc == 23) checkOutput("timeout.flag23", 8'(aTo), 8'd0);
      if (cyc == 24) checkOutput("timeout.state24", 8'(aState), 8'd5);
      if (cyc == 24) checkOutput("timeout.flag24", 8'(aTo), 8'd1);
      if (cyc >= 24) checkOutput("timeout.soc_rst_n", 8'(aSocN), 8'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
    checkOutput("timeout.ext_state", 8'(aState), 8'd0);
    for (int n = 28; n <= 37; n++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
      if (cyc == 37) checkOutput("recover.state37", 8'(aState), 8'd3);
      if (cyc == 38) checkOutput("recover.state38", 8'(aState), 8'd4);
      if (cyc == 38) checkOutput("recover.flag", 8'(aTo), 8'd1);
    end

    $display("[TB] run disturbances");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    checkOutput("calibdrop.state", 8'(aState), 8'd1);
    checkOutput("calibdrop.soc_rst_n", 8'(aSocN), 8'd0);
    for (int n = 39; n <= 44; n++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
      if (cyc == 44) checkOutput("rerelease.soc_rst_n44", 8'(aSocN), 8'd0);
      if (cyc == 45) checkOutput("rerelease.soc_rst_n45", 8'(aSocN), 8'd1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    checkOutput("lockdrop.state", 8'(aState), 8'd0);
    checkOutput("lockdrop.dram_rst", 8'(aDram), 8'd1);
    checkOutput("lockdrop.flag", 8'(aTo), 8'd1);

    $display("[TB] boot mode latch");
    doReset();
    checkOutput("latch.flag_cleared", 8'(aTo), 8'd0);
    for (int n = 1; n <= 14; n++) begin
      bm = (n == 9) ? 2'b01 : (n == 10) ? 2'b11 : (n > 10) ? 2'(n) : 2'b00;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, bm);
      if (cyc == 10) checkOutput("latch.before", 8'(aBmo), 8'd0);
      if (cyc >= 11) checkOutput("latch.held", 8'(aBmo), 8'd3);
    end

    $display("[TB] no-DRAM reset during SOC_RST");
    doReset();
    for (int n = 1; n <= 4; n++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'b10);
    checkOutput("nodram.socrst_state", 8'(bState), 8'd3);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b10);
    checkOutput("nodram.rst_state", 8'(bState), 8'd0);
    checkOutput("nodram.rst_dram", 8'(bDram), 8'd1);
    checkOutput("nodram.rst_soc_rst_n", 8'(bSocN), 8'd0);
    checkOutput("nodram.rst_ready", 8'(bReady), 8'd0);

    $display("[TB] randomized phase");
    for (int seg = 0; seg < 3; seg++) begin
      for (int n = 0; n < 1000; n++) begin
        logic r, l, e, c;
        r = ($urandom_range(0, 499) == 0);
        l = ($urandom_range(0, 49) != 0);
        e = ($urandom_range(0, 99) == 0);
        case (seg)
          0:       c = ($urandom_range(0, 15) != 0);
          1:       c = ($urandom_range(0, 39) == 0);
          default: c = ($urandom_range(0, 1) == 0);
        endcase
        applyStimulus(r, l, e, c, 2'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
